// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the round-robin SRAM arbiter.
package sram_arb_pkg;

  // Access sequencer states: one SETUP cycle, ACCESS_CYCLES strobe cycles, one HOLD cycle.
  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } arb_state_e;

  // Operation latched at grant time.
  typedef enum logic {
    OP_RD,
    OP_WR
  } arb_op_e;

  localparam int DEFAULT_ACCESS_CYCLES = 2;

  // grant_id and the round-robin pointer are always 3 bits wide (up to 8 requesters).
  localparam int GRANT_W = 3;

endpackage

// File: rtl/sram_rr_arbiter_rr_select.sv
// Combinational round-robin picker: the first pending requester after the
// pointer, wrapping modulo NUM_REQ.
module rr_select
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 5
) (
  input  logic [NUM_REQ-1:0] pend_i,
  input  logic [GRANT_W-1:0] pointer_i,
  output logic [GRANT_W-1:0] grant_o,
  output logic               valid_o
);

  // idxAt[r] is the requester index that sits r+1 positions after the pointer.
  logic [GRANT_W-1:0] idxAt [NUM_REQ];
  logic [NUM_REQ-1:0] hitAt;
  logic [NUM_REQ:0]   seen;
  logic [GRANT_W-1:0] acc [NUM_REQ+1];

  assign seen[0] = 1'b0;
  assign acc[0]  = '0;

  // Walk the search order; only the first pending position contributes its index.
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_rank
    assign idxAt[r]  = GRANT_W'((int'(pointer_i) + 1 + r) % NUM_REQ);
    assign hitAt[r]  = pend_i[idxAt[r]];
    assign seen[r+1] = seen[r] | hitAt[r];
    assign acc[r+1]  = acc[r] | ((hitAt[r] && !seen[r]) ? idxAt[r] : '0);
  end

  assign valid_o = seen[NUM_REQ];
  assign grant_o = acc[NUM_REQ];

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter and access sequencer sharing one async SRAM port
// between NUM_REQ requesters, with fixed setup/strobe/hold timing.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ       = 5,
  parameter int AW            = 16,
  parameter int DW            = 16,
  parameter int ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [NUM_REQ-1:0]    writeRequest,
  input  logic [NUM_REQ-1:0]    readRequest,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  input  logic [DW-1:0]         sram_rdata,
  output logic [AW-1:0]         addressToSRAM,
  output logic [DW-1:0]         sram_wdata,
  output logic                  drive_en,
  output logic                  SRAM_CE_N,
  output logic                  SRAM_WE_N,
  output logic                  SRAM_OE_N,
  output logic [DW-1:0]         DataToCPUs,
  output logic [NUM_REQ-1:0]    requestDone,
  output logic [GRANT_W-1:0]    grant_id
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(ACCESS_CYCLES - 1);

  arb_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic [GRANT_W-1:0] ptr_q;
  logic [GRANT_W-1:0] grant_q;
  arb_op_e            op_q;
  logic [AW-1:0]      addr_q;
  logic [DW-1:0]      wdata_q;
  logic               ceN_q;
  logic               weN_q;
  logic               oeN_q;
  logic               drive_q;
  logic [DW-1:0]      rdata_q;
  logic [NUM_REQ-1:0] done_q;

  logic [NUM_REQ-1:0] pend;
  logic [GRANT_W-1:0] selGrant;
  logic               selValid;

  logic [AW-1:0]      reqAddrArr  [NUM_REQ];
  logic [DW-1:0]      reqWdataArr [NUM_REQ];
  logic [NUM_REQ-1:0] doneVec_d;
  arb_op_e            op_d;
  logic [AW-1:0]      addr_d;
  logic [DW-1:0]      wdata_d;

  assign pend = writeRequest | readRequest;

  rr_select #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_select (
    .pend_i   (pend),
    .pointer_i(ptr_q),
    .grant_o  (selGrant),
    .valid_o  (selValid)
  );

  // Unpack per-requester fields and build the one-hot completion vector for the current grant.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign reqAddrArr[i]  = req_addr[i*AW +: AW];
    assign reqWdataArr[i] = req_wdata[i*DW +: DW];
    assign doneVec_d[i]   = (grant_q == GRANT_W'(i));
  end

  // Values latched at the grant edge; write wins when a requester asks for both.
  assign op_d    = writeRequest[selGrant] ? OP_WR : OP_RD;
  assign addr_d  = reqAddrArr[selGrant];
  assign wdata_d = reqWdataArr[selGrant];

  // Sequencer FSM with registered SRAM strobes, bus enable, read data and done pulse.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= GRANT_W'(NUM_REQ - 1);
      grant_q <= '0;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      ceN_q   <= 1'b1;
      weN_q   <= 1'b1;
      oeN_q   <= 1'b1;
      drive_q <= 1'b0;
      rdata_q <= '0;
      done_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (selValid) begin
            state_q <= SETUP;
            grant_q <= selGrant;
            op_q    <= op_d;
            addr_q  <= addr_d;
            ceN_q   <= 1'b0;
            drive_q <= (op_d == OP_WR);
            if (op_d == OP_WR) begin
              wdata_q <= wdata_d;
            end
          end
        end
        SETUP: begin
          state_q <= ACCESS;
          cnt_q   <= '0;
          if (op_q == OP_WR) begin
            weN_q <= 1'b0;
          end else begin
            oeN_q <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt_q == LAST_CNT) begin
            state_q <= HOLD;
            weN_q   <= 1'b1;
            oeN_q   <= 1'b1;
            done_q  <= doneVec_d;
            if (op_q == OP_RD) begin
              rdata_q <= sram_rdata;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          state_q <= IDLE;
          done_q  <= '0;
          ceN_q   <= 1'b1;
          drive_q <= 1'b0;
          ptr_q   <= grant_q;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign addressToSRAM = addr_q;
  assign sram_wdata    = wdata_q;
  assign drive_en      = drive_q;
  assign SRAM_CE_N     = ceN_q;
  assign SRAM_WE_N     = weN_q;
  assign SRAM_OE_N     = oeN_q;
  assign DataToCPUs    = rdata_q;
  assign requestDone   = done_q;
  assign grant_id      = grant_q;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Self-checking bench for sram_rr_arbiter: directed scenarios plus randomized
// rounds compared against a transaction-level round-robin and memory model.
module tb_sram_rr_arbiter;

  localparam int NREQ = 5;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int ACC  = 2;

  logic              clock = 1'b0;
  logic              resetN;
  logic [NREQ-1:0]   writeRequest;
  logic [NREQ-1:0]   readRequest;
  logic [NREQ*AW-1:0] reqAddr;
  logic [NREQ*DW-1:0] reqWdata;
  logic [DW-1:0]     sramRdata;
  logic [AW-1:0]     addressToSRAM;
  logic [DW-1:0]     sramWdata;
  logic              driveEn;
  logic              ceN;
  logic              weN;
  logic              oeN;
  logic [DW-1:0]     dataToCPUs;
  logic [NREQ-1:0]   requestDone;
  logic [2:0]        grantId;

  // Test memory behind the tristate, and the reference model's view of it.
  logic [15:0] testMem [0:255];
  logic [15:0] refMem  [0:255];

  int testsRun  = 0;
  int failCount = 0;

  // Per-round request description.
  logic [NREQ-1:0] wrMask;
  logic [NREQ-1:0] rdMask;
  logic [15:0]     addrArr [NREQ];
  logic [15:0]     dataArr [NREQ];
  int              refPtr;
  logic [15:0]     refData;

  int weRun = 0;
  int oeRun = 0;

  sram_rr_arbiter #(
    .NUM_REQ(NREQ),
    .AW(AW),
    .DW(DW),
    .ACCESS_CYCLES(ACC)
  ) dut (
    .Clk          (clock),
    .Reset        (resetN),
    .writeRequest (writeRequest),
    .readRequest  (readRequest),
    .req_addr     (reqAddr),
    .req_wdata    (reqWdata),
    .sram_rdata   (sramRdata),
    .addressToSRAM(addressToSRAM),
    .sram_wdata   (sramWdata),
    .drive_en     (driveEn),
    .SRAM_CE_N    (ceN),
    .SRAM_WE_N    (weN),
    .SRAM_OE_N    (oeN),
    .DataToCPUs   (dataToCPUs),
    .requestDone  (requestDone),
    .grant_id     (grantId)
  );

  always #5 clock = ~clock;

  // Async SRAM read path: a marker value whenever the chip is not being read.
  assign sramRdata = (!ceN && !oeN) ? testMem[addressToSRAM[7:0]] : 16'hDEAD;

  // SRAM write: stores whatever is driven while the write strobe is low.
  always @(posedge clock) begin
    if (!ceN && !weN && driveEn) testMem[addressToSRAM[7:0]] <= sramWdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  // Bus protocol monitor: strobe exclusivity, no drive while reading, strobe widths.
  always @(negedge clock) begin
    if (!resetN) begin
      weRun = 0;
      oeRun = 0;
    end else begin
      checkOutput("strobeOverlap", 32'(!weN && !oeN), 32'd0);
      checkOutput("driveDuringRead", 32'(driveEn && !oeN), 32'd0);
      if (!weN) weRun++;
      else if (weRun != 0) begin
        checkOutput("weWidth", 32'(weRun), 32'(ACC));
        weRun = 0;
      end
      if (!oeN) oeRun++;
      else if (oeRun != 0) begin
        checkOutput("oeWidth", 32'(oeRun), 32'(ACC));
        oeRun = 0;
      end
    end
  end

  task automatic applyStimulus();
    writeRequest = wrMask;
    readRequest  = rdMask;
    reqAddr  = {addrArr[4], addrArr[3], addrArr[2], addrArr[1], addrArr[0]};
    reqWdata = {dataArr[4], dataArr[3], dataArr[2], dataArr[1], dataArr[0]};
  endtask

  // Reference round-robin choice: step forward from the pointer until a pending requester is found.
  function automatic int refPick(input logic [NREQ-1:0] pend, input int ptr);
    int idx = ptr;
    for (int n = 0; n < NREQ; n++) begin
      idx = (idx + 1) % NREQ;
      if (pend[idx[2:0]]) return idx;
    end
    return 0;
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ceN"}, 32'(ceN), 32'd1);
    checkOutput({tag, "_weN"}, 32'(weN), 32'd1);
    checkOutput({tag, "_oeN"}, 32'(oeN), 32'd1);
    checkOutput({tag, "_drive"}, 32'(driveEn), 32'd0);
    checkOutput({tag, "_done"}, 32'(requestDone), 32'd0);
    checkOutput({tag, "_grant"}, 32'(grantId), 32'd0);
    checkOutput({tag, "_data"}, 32'(dataToCPUs), 32'd0);
  endtask

  task automatic doReset();
    @(negedge clock);
    resetN = 1'b0;
    wrMask = '0;
    rdMask = '0;
    applyStimulus();
    repeat (2) @(negedge clock);
    checkResetState("reset");
    checkOutput("reset_addr", 32'(addressToSRAM), 32'd0);
    checkOutput("reset_wdata", 32'(sramWdata), 32'd0);
    resetN  = 1'b1;
    refPtr  = NREQ - 1;
    refData = '0;
  endtask

  // Raise every request of the round at once (DUT idle), hold each until its done pulse.
  task automatic runRound();
    logic [NREQ-1:0] pending;
    int expGap;
    pending = wrMask | rdMask;
    expGap  = 4;
    applyStimulus();
    while (pending != '0) begin
      int g;
      int waited;
      logic [2:0] gi;
      logic [NREQ-1:0] expDone;
      g = refPick(pending, refPtr);
      gi = 3'(g);
      expDone = 5'b00001 << gi;
      waited = 0;
      do begin
        @(negedge clock);
        waited++;
      end while (requestDone == '0 && waited < 12);
      checkOutput("doneLatency", 32'(waited), 32'(expGap));
      checkOutput("doneOneHot", 32'(requestDone), 32'(expDone));
      checkOutput("grantId", 32'(grantId), 32'(gi));
      if (wrMask[gi]) begin
        refMem[addrArr[gi][7:0]] = dataArr[gi];
        checkOutput("memWrite", 32'(testMem[addrArr[gi][7:0]]), 32'(dataArr[gi]));
      end else begin
        refData = refMem[addrArr[gi][7:0]];
      end
      checkOutput("readData", 32'(dataToCPUs), 32'(refData));
      pending[gi] = 1'b0;
      wrMask[gi]  = 1'b0;
      rdMask[gi]  = 1'b0;
      refPtr      = g;
      applyStimulus();
      expGap = 5;
    end
    @(negedge clock);
    checkOutput("idleNoDone", 32'(requestDone), 32'd0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      testMem[a] = '0;
      refMem[a]  = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      addrArr[i] = '0;
      dataArr[i] = '0;
    end
    wrMask = '0;
    rdMask = '0;
    applyStimulus();
    resetN  = 1'b1;
    refPtr  = NREQ - 1;
    refData = '0;
    #2 resetN = 1'b0;
    doReset();

    // Single write from requester 2, with cycle-level timing and in-flight input changes.
    @(negedge clock);
    wrMask = 5'b00100;
    addrArr[2] = 16'h0010;
    dataArr[2] = 16'hBEEF;
    applyStimulus();
    @(negedge clock);
    checkOutput("setup_ceN", 32'(ceN), 32'd0);
    checkOutput("setup_weN", 32'(weN), 32'd1);
    checkOutput("setup_drive", 32'(driveEn), 32'd1);
    checkOutput("setup_addr", 32'(addressToSRAM), 32'h0010);
    checkOutput("setup_wdata", 32'(sramWdata), 32'hBEEF);
    checkOutput("setup_grant", 32'(grantId), 32'd2);
    reqAddr[47:32]  = 16'h0033;
    reqWdata[47:32] = 16'h1234;
    @(negedge clock);
    checkOutput("acc1_weN", 32'(weN), 32'd0);
    checkOutput("acc1_oeN", 32'(oeN), 32'd1);
    @(negedge clock);
    checkOutput("acc2_weN", 32'(weN), 32'd0);
    checkOutput("acc2_addr", 32'(addressToSRAM), 32'h0010);
    @(negedge clock);
    checkOutput("hold_done", 32'(requestDone), 32'b00100);
    checkOutput("hold_weN", 32'(weN), 32'd1);
    checkOutput("hold_ceN", 32'(ceN), 32'd0);
    checkOutput("hold_drive", 32'(driveEn), 32'd1);
    wrMask = '0;
    applyStimulus();
    refMem[8'h10] = 16'hBEEF;
    refPtr = 2;
    @(negedge clock);
    checkOutput("idle_ceN", 32'(ceN), 32'd1);
    checkOutput("idle_drive", 32'(driveEn), 32'd0);
    checkOutput("idle_done", 32'(requestDone), 32'd0);
    checkOutput("mem_0010", 32'(testMem[8'h10]), 32'hBEEF);
    checkOutput("mem_0033", 32'(testMem[8'h33]), 32'd0);

    // Readback by requester 0.
    rdMask = 5'b00001;
    addrArr[0] = 16'h0010;
    runRound();

    // Contention from reset: all five pending.
    doReset();
    wrMask = 5'b10101;
    rdMask = 5'b01010;
    for (int i = 0; i < NREQ; i++) begin
      addrArr[i] = 16'(i);
      dataArr[i] = 16'(16'hA000 + i);
    end
    runRound();

    // Pointer fairness: 1 and 3 alternate; then 0 beats 1 with pointer at 4.
    rdMask = 5'b01010;
    runRound();
    rdMask = 5'b01010;
    runRound();
    rdMask = 5'b10000;
    runRound();
    rdMask = 5'b00011;
    runRound();

    // Write and read requested together: write wins, read data untouched.
    wrMask = 5'b10000;
    rdMask = 5'b10000;
    addrArr[4] = 16'h0020;
    dataArr[4] = 16'h5A5A;
    runRound();
    rdMask = 5'b10000;
    runRound();

    // Reset during a write strobe: everything released at once, no done pulse.
    rdMask = 5'b00001;
    addrArr[0] = 16'h0020;
    runRound();
    wrMask = 5'b01000;
    addrArr[3] = 16'h00FF;
    dataArr[3] = 16'h7777;
    applyStimulus();
    @(negedge clock);
    @(negedge clock);
    checkOutput("preAbort_weN", 32'(weN), 32'd0);
    #2 resetN = 1'b0;
    #1;
    checkResetState("abort");
    wrMask = '0;
    applyStimulus();
    @(negedge clock);
    #1 resetN = 1'b1;
    refPtr  = NREQ - 1;
    refData = '0;
    @(negedge clock);
    for (int c = 0; c < 6; c++) begin
      checkOutput("abortNoDone", 32'(requestDone), 32'd0);
      @(negedge clock);
    end
    rdMask = 5'b01001;
    addrArr[0] = 16'h0010;
    addrArr[3] = 16'h0020;
    runRound();

    // Randomized rounds against the reference model.
    for (int r = 0; r < 30; r++) begin
      wrMask = 5'($urandom_range(0, 31));
      rdMask = 5'($urandom_range(0, 31));
      if ((wrMask | rdMask) == '0) rdMask = 5'b00001;
      for (int i = 0; i < NREQ; i++) begin
        addrArr[i] = 16'($urandom_range(0, 63));
        dataArr[i] = 16'($urandom);
      end
      runRound();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
Round-robin arbiter and access sequencer that shares the single 16-bit async SRAM port between NUM_REQ CPU requesters.
- Each requester presents a level read or write request with address and write data.
- Block grants one requester at a time, drives SRAM address, strobes and tristate-enable with fixed setup/strobe/hold timing, and returns read data.
- Issues a one-cycle done pulse per request.
- Sits between the CPU cores and the tristate/SRAM (or test memory) pair.

Parameters:
NUM_REQ, 5, number of requesters (1..8).
AW, 16, address width.
DW, 16, data width.
ACCESS_CYCLES, 2, cycles WE_N/OE_N held low per access (>=1).

Ports:
Clk  in  1  system clock, all state on rising edge.
Reset  in  1  asynchronous, active-low reset.
writeRequest  in  NUM_REQ  level write request per requester.
readRequest  in  NUM_REQ  level read request per requester.
req_addr  in  NUM_REQ*AW  packed addresses, requester i at [i*AW +: AW].
req_wdata  in  NUM_REQ*DW  packed write data, same packing.
sram_rdata  in  DW  data read back from tristate Data_read.
addressToSRAM  out  AW  SRAM address.
sram_wdata  out  DW  data to tristate Data_write.
drive_en  out  1  tristate output enable, 1 = arbiter drives bus.
SRAM_CE_N  out  1  chip enable, active low.
SRAM_WE_N  out  1  write enable, active low.
SRAM_OE_N  out  1  output enable, active low.
DataToCPUs  out  DW  last read data, shared by all requesters.
requestDone  out  NUM_REQ  one-hot, one-cycle completion pulse.
grant_id  out  3  index of requester currently or last served.

Behaviour:
Reset (async, Reset=0):
- State IDLE; CE_N/WE_N/OE_N=1; drive_en=0.
- addressToSRAM, sram_wdata, DataToCPUs = 0; requestDone = 0.
- RR pointer = NUM_REQ-1, so requester 0 wins first; grant_id=0.
- Reset asserted mid-access aborts at once: strobes high and bus released asynchronously, no done pulse. Requester must re-request after reset.

Request/grant:
- pend[i] = writeRequest[i] | readRequest[i].
- If both bits of one requester are set, write is taken and read ignored for that grant.
- In IDLE, if any pend, grant g = first pend index searching pointer+1, pointer+2, ... modulo NUM_REQ.
- At grant edge, latch op, address and wdata of g. Later changes on the req_* inputs do not affect the access in flight.

FSM (registered outputs, values below apply during the named state):
- IDLE: strobes high, drive_en=0, CE_N=1. Any pend -> SETUP.
- SETUP (1 cycle): CE_N=0, addressToSRAM valid, WE_N=OE_N=1. drive_en=1 and sram_wdata valid if write. -> ACCESS, cnt=0.
- ACCESS (ACCESS_CYCLES cycles): write asserts WE_N=0; read asserts OE_N=0. On last cycle, sram_rdata is captured into DataToCPUs (read only). -> HOLD.
- HOLD (1 cycle): WE_N=OE_N=1; CE_N=0; address and drive_en held (write data hold time). requestDone[g]=1. Pointer <= g. -> IDLE.
- Latency: request visible in IDLE at cycle 0 -> done pulse in cycle ACCESS_CYCLES+2 (cycle 4 at default). Minimum spacing between grants is ACCESS_CYCLES+3 cycles.
- Requester drops its request in the cycle after done. The IDLE cycle guarantees no double service.
- WE_N and OE_N are never low together. drive_en is never 1 while OE_N is 0.
- DataToCPUs holds its value until the next completed read; writes do not alter it.
- Fairness: with all requesters continuously pending, service order is 0,1,2,3,4,0,...

Decomposition:
- Package sram_arb_pkg: state enum (IDLE, SETUP, ACCESS, HOLD), op enum (OP_RD, OP_WR), default ACCESS_CYCLES constant.
- Sub-module rr_select: combinational round-robin picker. Inputs: pend vector and pointer. Outputs: grant index and valid.
- FSM, latches and counter live in the top.

Test Plan:
- Reset then single write: req 2 writes 0xBEEF to 0x0010 -> SETUP/ACCESS/HOLD sequence, WE_N low exactly 2 cycles, requestDone=5'b00100 in cycle 4. Test memory holds 0xBEEF at 0x0010.
- Readback: req 0 reads 0x0010 -> OE_N low 2 cycles, drive_en=0 throughout, DataToCPUs=0xBEEF with requestDone[0] pulse.
- Contention: all 5 requesters pending from reset -> grants in order 0,1,2,3,4; each done pulse 5 cycles apart; no double grant.
- Pointer fairness: reqs 1 and 3 held continuously after 3 served -> order 1,3,1,3. Req 0 asserted later is served before 1 if pointer=4.
- Read+write same requester: writeRequest[4]=readRequest[4]=1 -> write performed, DataToCPUs unchanged.
- Reset mid-ACCESS of a write: Reset low for 1 cycle -> WE_N=1 and drive_en=0 immediately, no requestDone, FSM IDLE, pointer back to NUM_REQ-1.
